// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ADDR   = 4'd1,
        S_WDATA  = 4'd2,
        S_WR     = 4'd3,
        S_RD     = 4'd4,
        S_RWAIT  = 4'd5,
        S_TXLOAD = 4'd6,
        S_TXWAIT = 4'd7,
        S_ERR    = 4'd8
    } cmd_state_e;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    localparam logic [1:0] ERR_RD_TIMEOUT = 2'b00;
    localparam logic [1:0] ERR_BAD_OP     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT    = 2'b10;
    localparam logic [1:0] ERR_OVERRUN    = 2'b11;

    // States in which a newly received byte cannot be consumed.
    function automatic logic is_overrun_state(input cmd_state_e s);
        return (s == S_RD) || (s == S_RWAIT) || (s == S_WR) ||
               (s == S_TXLOAD) || (s == S_TXWAIT) || (s == S_ERR);
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte watchdog: counts baud ticks while enabled, cleared by each received byte.
// Latency: expire is combinational from the count register, one cycle after the final tick.
// Backpressure: none; saturates at the limit and holds until cleared or disabled.
module uart_cmd_timeout #(
    parameter int TIMEOUT_BITS = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    input  logic tick_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_BITS + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_limit;

    assign at_limit = (cnt_q == CW'(TIMEOUT_BITS));
    assign expire_o = en_i && at_limit;

    // Counter next state: clear on byte or when idle, otherwise count ticks up to the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (tick_i && !at_limit) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles UART bytes into register read/write commands and returns the response bytes.
// Latency: reg_we/reg_re one cycle after the last command byte; tx_start one cycle after read data.
// Backpressure: waits on tx_busy per response byte; bytes arriving while busy are dropped and flagged.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_BITS = 40,
    parameter int RD_WAIT_MAX  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              baud_tick,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [31:0]       reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [31:0]       reg_rdata,
    input  logic              reg_rvalid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              err_pulse,
    output logic [1:0]        err_code
);

    localparam int RW_W = $clog2(RD_WAIT_MAX + 1);

    cmd_state_e        state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic [31:0]       rdata_q,     rdata_d;
    logic [1:0]        byte_cnt_q,  byte_cnt_d;
    logic [1:0]        rsp_idx_q,   rsp_idx_d;
    logic              rsp_multi_q, rsp_multi_d;
    logic [7:0]        rsp_byte_q,  rsp_byte_d;
    logic              is_rd_q,     is_rd_d;
    logic              guard_q,     guard_d;
    logic [RW_W-1:0]   rdw_cnt_q,   rdw_cnt_d;

    logic              to_en;
    logic              to_expire;
    logic [7:0]        cur_byte;

    assign to_en = (state_q == S_ADDR) || (state_q == S_WDATA);

    uart_cmd_timeout #(
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (rx_valid),
        .en_i     (to_en),
        .tick_i   (baud_tick),
        .expire_o (to_expire)
    );

    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = (state_q == S_WR);
    assign reg_re    = (state_q == S_RD);
    assign busy      = (state_q != S_IDLE);

    // Select the response byte: read data MSB first, or the single ACK/ERR byte.
    always_comb begin
        cur_byte = rsp_byte_q;
        if (rsp_multi_q) begin
            case (rsp_idx_q)
                2'd0:    cur_byte = rdata_q[31:24];
                2'd1:    cur_byte = rdata_q[23:16];
                2'd2:    cur_byte = rdata_q[15:8];
                default: cur_byte = rdata_q[7:0];
            endcase
        end
    end

    // tx_data only carries a byte while a response is in flight, so it stays stable until busy drops.
    assign tx_data = ((state_q == S_TXLOAD) || (state_q == S_TXWAIT)) ? cur_byte : 8'h00;

    // Command FSM: next state, datapath updates and strobes.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        byte_cnt_d  = byte_cnt_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_multi_d = rsp_multi_q;
        rsp_byte_d  = rsp_byte_q;
        is_rd_d     = is_rd_q;
        guard_d     = guard_q;
        rdw_cnt_d   = rdw_cnt_q;
        tx_start    = 1'b0;
        err_pulse   = 1'b0;
        err_code    = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_WR) begin
                        is_rd_d = 1'b0;
                        state_d = S_ADDR;
                    end else if (rx_data == OP_RD) begin
                        is_rd_d = 1'b1;
                        state_d = S_ADDR;
                    end else begin
                        err_pulse = 1'b1;
                        err_code  = ERR_BAD_OP;
                        state_d   = S_ERR;
                    end
                end
            end
            S_ADDR: begin
                // A byte arriving in the expiry cycle still counts as on time.
                if (rx_valid) begin
                    addr_d = rx_data[ADDR_W-1:0];
                    if (is_rd_q) begin
                        state_d = S_RD;
                    end else begin
                        byte_cnt_d = 2'd0;
                        state_d    = S_WDATA;
                    end
                end else if (to_expire) begin
                    err_pulse = 1'b1;
                    err_code  = ERR_TIMEOUT;
                    state_d   = S_IDLE;
                end
            end
            S_WDATA: begin
                if (rx_valid) begin
                    wdata_d    = {wdata_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WR;
                    end
                end else if (to_expire) begin
                    err_pulse = 1'b1;
                    err_code  = ERR_TIMEOUT;
                    state_d   = S_IDLE;
                end
            end
            S_WR: begin
                rsp_byte_d  = RSP_ACK;
                rsp_multi_d = 1'b0;
                rsp_idx_d   = 2'd0;
                state_d     = S_TXLOAD;
            end
            S_RD: begin
                rdw_cnt_d = '0;
                state_d   = S_RWAIT;
            end
            S_RWAIT: begin
                if (reg_rvalid) begin
                    rdata_d     = reg_rdata;
                    rsp_multi_d = 1'b1;
                    rsp_idx_d   = 2'd0;
                    state_d     = S_TXLOAD;
                end else if (rdw_cnt_q == RW_W'(RD_WAIT_MAX - 1)) begin
                    err_pulse = 1'b1;
                    err_code  = ERR_RD_TIMEOUT;
                    state_d   = S_ERR;
                end else begin
                    rdw_cnt_d = rdw_cnt_q + RW_W'(1);
                end
            end
            S_ERR: begin
                rsp_byte_d  = RSP_ERR;
                rsp_multi_d = 1'b0;
                rsp_idx_d   = 2'd0;
                state_d     = S_TXLOAD;
            end
            S_TXLOAD: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    guard_d  = 1'b1;
                    state_d  = S_TXWAIT;
                end
            end
            S_TXWAIT: begin
                // The transmitter may not raise tx_busy until the cycle after tx_start.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!tx_busy) begin
                    if (rsp_multi_q && (rsp_idx_q != 2'd3)) begin
                        rsp_idx_d = rsp_idx_q + 2'd1;
                        state_d   = S_TXLOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Drop bytes that arrive while a command is executing; a read timeout in the same
        // cycle keeps its own code.
        if (rx_valid && is_overrun_state(state_q) && !err_pulse) begin
            err_pulse = 1'b1;
            err_code  = ERR_OVERRUN;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            byte_cnt_q  <= '0;
            rsp_idx_q   <= '0;
            rsp_multi_q <= 1'b0;
            rsp_byte_q  <= '0;
            is_rd_q     <= 1'b0;
            guard_q     <= 1'b0;
            rdw_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            byte_cnt_q  <= byte_cnt_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_multi_q <= rsp_multi_d;
            rsp_byte_q  <= rsp_byte_d;
            is_rd_q     <= is_rd_d;
            guard_q     <= guard_d;
            rdw_cnt_q   <= rdw_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized command stream against an event-list model of the controller.
// Latency: checks strobe timing relative to the last command byte and read data.
// Backpressure: emulates a transmitter with random busy time and checks the handshake.
module tb_uart_cmd_ctrl;

    localparam int TB_ADDR_W = 6;
    localparam logic [7:0] AMASK = 8'h3F;

    logic                 clk;
    logic                 rst_n;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 baud_tick;
    logic [TB_ADDR_W-1:0] reg_addr;
    logic [31:0]          reg_wdata;
    logic                 reg_we;
    logic                 reg_re;
    logic [31:0]          reg_rdata;
    logic                 reg_rvalid;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic                 busy;
    logic                 err_pulse;
    logic [1:0]           err_code;

    uart_cmd_ctrl #(
        .ADDR_W       (TB_ADDR_W),
        .TIMEOUT_BITS (40),
        .RD_WAIT_MAX  (255)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .baud_tick  (baud_tick),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .err_pulse  (err_pulse),
        .err_code   (err_code)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_rx_cyc = 0;
    int proto_viol  = 0;
    logic [7:0] tx_hold = 8'h00;

    logic [39:0] obs_we[$],  exp_we[$];
    logic [7:0]  obs_re[$],  exp_re[$];
    logic [7:0]  obs_tx[$],  exp_tx[$];
    logic [1:0]  obs_err[$], exp_err[$];
    int          obs_we_cyc[$], obs_re_cyc[$], obs_tx_cyc[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Baud tick every fourth clock.
    initial begin
        int tdiv;
        tdiv = 0;
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tdiv = (tdiv + 1) % 4;
            baud_tick = (tdiv == 0);
        end
    end

    // Output monitor: collects strobes as events, checks the transmit handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (reg_we) begin
                    obs_we.push_back({2'b00, reg_addr, reg_wdata});
                    obs_we_cyc.push_back(cyc);
                end
                if (reg_re) begin
                    obs_re.push_back({2'b00, reg_addr});
                    obs_re_cyc.push_back(cyc);
                end
                if (err_pulse) obs_err.push_back(err_code);
                if (tx_start && tx_busy) proto_viol++;
                if (tx_busy && (tx_data != tx_hold)) proto_viol++;
                if (tx_start) begin
                    obs_tx.push_back(tx_data);
                    obs_tx_cyc.push_back(cyc);
                    tx_hold = tx_data;
                end
            end
        end
    end

    // Transmitter: busy from the cycle after tx_start for a random number of cycles.
    initial begin
        int unsigned d;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                d = $urandom_range(2, 6);
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (d) begin
                    @(posedge clk);
                    #1;
                end
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failed %0d of %0d", n_fail, n_tests);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) step();
        rx_data     = b;
        rx_valid    = 1'b1;
        last_rx_cyc = cyc;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (3) step();
        while ((busy || tx_busy) && n < 4000) begin
            step();
            n++;
        end
        check_eq({tag, " idle"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic compare_events(input string tag);
        check_eq({tag, " we_count"}, obs_we.size(), exp_we.size());
        for (int i = 0; i < obs_we.size() && i < exp_we.size(); i++)
            check_eq({tag, " we_addr_data"}, obs_we[i], exp_we[i]);
        check_eq({tag, " re_count"}, obs_re.size(), exp_re.size());
        for (int i = 0; i < obs_re.size() && i < exp_re.size(); i++)
            check_eq({tag, " re_addr"}, obs_re[i], exp_re[i]);
        check_eq({tag, " tx_count"}, obs_tx.size(), exp_tx.size());
        for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++)
            check_eq({tag, " tx_byte"}, obs_tx[i], exp_tx[i]);
        check_eq({tag, " err_count"}, obs_err.size(), exp_err.size());
        for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++)
            check_eq({tag, " err_code"}, obs_err[i], exp_err[i]);
        obs_we.delete();  exp_we.delete();  obs_we_cyc.delete();
        obs_re.delete();  exp_re.delete();  obs_re_cyc.delete();
        obs_tx.delete();  exp_tx.delete();  obs_tx_cyc.delete();
        obs_err.delete(); exp_err.delete();
    endtask

    task automatic run_write(input string tag, input logic [7:0] addr, input logic [31:0] data,
                             input int gmax, input bit overrun);
        int d0_cyc;
        int n;
        exp_we.push_back({addr & AMASK, data});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57, $urandom_range(1, gmax));
        send_byte(addr, $urandom_range(0, gmax));
        for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8], $urandom_range(0, gmax));
        d0_cyc = last_rx_cyc;
        if (overrun) begin
            n = 0;
            while (!tx_busy && n < 50) begin
                step();
                n++;
            end
            check_eq({tag, " ovr_txbusy"}, {63'd0, tx_busy}, 64'd1);
            check_eq({tag, " ovr_busy"}, {63'd0, busy}, 64'd1);
            send_byte(8'($urandom), 0);
            exp_err.push_back(2'b11);
        end
        wait_idle(tag);
        if (obs_we_cyc.size() > 0)
            check_eq({tag, " we_latency"}, obs_we_cyc[0] - d0_cyc, 1);
        compare_events(tag);
    endtask

    task automatic run_read(input string tag, input logic [7:0] addr, input logic [31:0] data,
                            input int delay, input bit respond, input int gmax);
        int a_cyc;
        int rv_cyc;
        rv_cyc = 0;
        exp_re.push_back(addr & AMASK);
        send_byte(8'h52, $urandom_range(1, gmax));
        send_byte(addr, $urandom_range(0, gmax));
        a_cyc = last_rx_cyc;
        if (respond) begin
            repeat (delay) step();
            reg_rdata  = data;
            reg_rvalid = 1'b1;
            rv_cyc     = cyc;
            step();
            reg_rvalid = 1'b0;
            reg_rdata  = $urandom;
            for (int i = 3; i >= 0; i--) exp_tx.push_back(data[8*i +: 8]);
        end else begin
            exp_err.push_back(2'b00);
            exp_tx.push_back(8'h45);
        end
        wait_idle(tag);
        if (obs_re_cyc.size() > 0)
            check_eq({tag, " re_latency"}, obs_re_cyc[0] - a_cyc, 1);
        if (respond && obs_tx_cyc.size() > 0)
            check_eq({tag, " rdata_to_tx"}, obs_tx_cyc[0] - rv_cyc, 1);
        compare_events(tag);
    endtask

    task automatic run_bad(input string tag, input logic [7:0] op);
        exp_err.push_back(2'b01);
        exp_tx.push_back(8'h45);
        send_byte(op, $urandom_range(1, 10));
        wait_idle(tag);
        compare_events(tag);
    endtask

    // Partial command followed by silence: nbytes after the opcode (read allows 0 only).
    task automatic run_abandon(input string tag, input bit is_rd, input int nbytes);
        exp_err.push_back(2'b10);
        send_byte(is_rd ? 8'h52 : 8'h57, $urandom_range(1, 10));
        for (int i = 0; i < nbytes; i++) send_byte(8'($urandom), $urandom_range(0, 20));
        repeat (200) step();
        wait_idle(tag);
        compare_events(tag);
    endtask

    initial begin
        logic [7:0]  a;
        logic [7:0]  op;
        logic [31:0] dt;
        int          kind;

        rst_n      = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        reg_rdata  = 32'h0;
        reg_rvalid = 1'b0;
        repeat (4) step();

        check_eq("rst reg_we",    {63'd0, reg_we},    64'd0);
        check_eq("rst reg_re",    {63'd0, reg_re},    64'd0);
        check_eq("rst tx_start",  {63'd0, tx_start},  64'd0);
        check_eq("rst busy",      {63'd0, busy},      64'd0);
        check_eq("rst err_pulse", {63'd0, err_pulse}, 64'd0);
        check_eq("rst reg_addr",  reg_addr,           64'd0);
        check_eq("rst reg_wdata", reg_wdata,          64'd0);
        check_eq("rst tx_data",   tx_data,            64'd0);
        rst_n = 1'b1;
        repeat (3) step();

        run_write("wr_deadbeef", 8'h10, 32'hDEADBEEF, 5, 1'b0);
        run_read("rd_01234567", 8'h22, 32'h01234567, 3, 1'b1, 5);
        run_bad("bad_41", 8'h41);
        run_abandon("timeout_wr", 1'b0, 2);
        run_read("rd_after_to", 8'h05, 32'hA5C3_0F96, 2, 1'b1, 5);
        run_write("overrun_k", 8'h33, 32'h1357_9BDF, 5, 1'b1);
        run_read("rd_timeout", 8'hC7, 32'h0, 0, 1'b0, 5);
        run_write("addr_mask", 8'hFF, 32'h0000_0001, 3, 1'b0);

        // Reset in the middle of a write command.
        send_byte(8'h57, 2);
        send_byte(8'h10, 2);
        send_byte(8'hAA, 2);
        step();
        rst_n = 1'b0;
        #1;
        check_eq("midrst reg_we",    {63'd0, reg_we},    64'd0);
        check_eq("midrst busy",      {63'd0, busy},      64'd0);
        check_eq("midrst err_pulse", {63'd0, err_pulse}, 64'd0);
        check_eq("midrst tx_start",  {63'd0, tx_start},  64'd0);
        check_eq("midrst reg_addr",  reg_addr,           64'd0);
        check_eq("midrst reg_wdata", reg_wdata,          64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();
        compare_events("midrst_quiet");
        run_write("after_rst", 8'h10, 32'hCAFE_F00D, 5, 1'b0);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                reg_rdata  = $urandom;
                reg_rvalid = 1'b1;
                step();
                reg_rvalid = 1'b0;
            end
            a    = 8'($urandom);
            dt   = $urandom;
            kind = $urandom_range(0, 11);
            if (kind <= 3) begin
                run_write("rnd_wr", a, dt, 30, 1'b0);
            end else if (kind <= 6) begin
                run_read("rnd_rd", a, dt, $urandom_range(1, 20), 1'b1, 30);
            end else if (kind == 7) begin
                op = 8'($urandom);
                while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
                run_bad("rnd_bad", op);
            end else if (kind == 8) begin
                if ($urandom_range(0, 1) == 1) run_abandon("rnd_to_rd", 1'b1, 0);
                else                           run_abandon("rnd_to_wr", 1'b0, $urandom_range(0, 4));
            end else if (kind == 9) begin
                run_write("rnd_ovr", a, dt, 20, 1'b1);
            end else if (kind == 10) begin
                run_read("rnd_rdto", a, dt, 0, 1'b0, 20);
            end else begin
                run_read("rnd_rd_fast", a, dt, 1, 1'b1, 3);
            end
        end

        check_eq("tx_handshake", proto_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
